// File: rtl/lsu_align_if.sv
// Pipeline-side request/response and data-memory bus of the load/store alignment unit.
interface lsu_align_if;
  logic        req_i;
  logic        st_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [31:0] daddr_o;
  logic [31:0] dwdata_o;
  logic [3:0]  we_o;
  logic [31:0] drdata_i;

  modport slave (
    input  req_i, st_i, funct3_i, addr_i, wdata_i, drdata_i,
    output ready_o, done_o, err_o, rdata_o, daddr_o, dwdata_o, we_o
  );

  modport master (
    output req_i, st_i, funct3_i, addr_i, wdata_i, drdata_i,
    input  ready_o, done_o, err_o, rdata_o, daddr_o, dwdata_o, we_o
  );
endinterface

// File: rtl/lsu_align.sv
// RV32I load/store alignment unit: turns B/H/W accesses into word-aligned memory beats.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two beats (ACC1, ACC2).
module lsu_align #(
  parameter int unsigned DMEM_BYTES = 128
) (
  input logic        clk,
  input logic        reset,
  lsu_align_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
`ifdef LSU_MISALIGNED_EN
    ACC2 = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t      state, nxt;
  logic [31:0] addr_q, wdata_q, lo_q, hi_q;
  logic [2:0]  f3_q;
  logic        st_q, err_q;
  logic        ready, accept;

  // request decode, evaluated on the incoming (not yet captured) request
  logic [2:0]  nb;
  logic [32:0] last;
  logic        ill, oob, mis, req_err;

  always_comb begin
    case (bus.funct3_i[1:0])
      2'b00:   nb = 3'd1;
      2'b01:   nb = 3'd2;
      default: nb = 3'd4;
    endcase
  end

  assign ill  = (bus.funct3_i == 3'b011) || (bus.funct3_i[2] && bus.funct3_i[1]) ||
                (bus.st_i && bus.funct3_i[2]);
  assign last = {1'b0, bus.addr_i} + {30'd0, nb} - 33'd1;
  assign oob  = last >= 33'(DMEM_BYTES);

`ifdef LSU_MISALIGNED_EN
  logic span, span_q;
  assign span = ({2'b00, bus.addr_i[1:0]} + {1'b0, nb}) > 4'd4;
  assign mis  = 1'b0;
`else
  assign mis  = (nb == 3'd2 && bus.addr_i[0]) || (nb == 3'd4 && bus.addr_i[1:0] != 2'b00);
`endif

  assign req_err = ill || oob || mis;
  assign ready   = (state == IDLE) || (state == DONE);
  assign accept  = ready && bus.req_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = !bus.req_i ? IDLE : (req_err ? DONE : ACC1);
`ifdef LSU_MISALIGNED_EN
      ACC1:       nxt = span_q ? ACC2 : DONE;
      ACC2:       nxt = DONE;
`else
      ACC1:       nxt = DONE;
`endif
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGNED_EN
      span_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q  <= bus.addr_i;
        wdata_q <= bus.wdata_i;
        f3_q    <= bus.funct3_i;
        st_q    <= bus.st_i;
        err_q   <= req_err;
        hi_q    <= '0;
`ifdef LSU_MISALIGNED_EN
        span_q  <= span;
`endif
      end
      if (state == ACC1) lo_q <= bus.drdata_i;
`ifdef LSU_MISALIGNED_EN
      if (state == ACC2) hi_q <= bus.drdata_i;
`endif
    end
  end

  // byte-lane mask across the two words, and the extended load result
  logic [3:0]  bm;
`ifdef LSU_MISALIGNED_EN
  logic [7:0]  m;
`else
  logic [3:0]  m;
`endif
  logic [31:0] raw, ext;

  always_comb begin
    case (f3_q[1:0])
      2'b00:   bm = 4'b0001;
      2'b01:   bm = 4'b0011;
      default: bm = 4'b1111;
    endcase
`ifdef LSU_MISALIGNED_EN
    m = {4'b0000, bm} << addr_q[1:0];
`else
    m = bm << addr_q[1:0];
`endif
    raw = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});
    case (f3_q)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  ext = {24'd0, raw[7:0]};
      3'b101:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    bus.ready_o  = ready;
    bus.done_o   = 1'b0;
    bus.err_o    = 1'b0;
    bus.rdata_o  = '0;
    bus.daddr_o  = '0;
    bus.dwdata_o = '0;
    bus.we_o     = '0;
    case (state)
      ACC1: begin
        bus.daddr_o  = {addr_q[31:2], 2'b00};
        bus.we_o     = st_q ? m[3:0] : 4'b0000;
        bus.dwdata_o = wdata_q << {addr_q[1:0], 3'b000};
      end
`ifdef LSU_MISALIGNED_EN
      ACC2: begin
        bus.daddr_o  = {addr_q[31:2], 2'b00} + 32'd4;
        bus.we_o     = st_q ? m[7:4] : 4'b0000;
        bus.dwdata_o = wdata_q >> (6'd32 - {1'b0, addr_q[1:0], 3'b000});
      end
`endif
      DONE: begin
        bus.done_o  = 1'b1;
        bus.err_o   = err_q;
        bus.rdata_o = (st_q || err_q) ? 32'd0 : ext;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align: byte-level reference memory predicts load data, error and latency.
module tb_lsu_align;
  localparam int DMEM = 128;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_align_if bus();
  lsu_align #(.DMEM_BYTES(DMEM)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  logic [7:0] mem     [DMEM];
  logic [7:0] ref_mem [DMEM];
  logic       bd_we   = 1'b0;
  logic [6:0] bd_addr = '0;
  logic [7:0] bd_data = '0;
  int cyc = 0, wr_count = 0;
  int n_cmp = 0, n_bad = 0;
  exp_t exp_q[$];
  int   acc_q[$], acc_log[$], done_log[$];

  wire [6:0] da = bus.daddr_o[6:0];
  assign bus.drdata_i = (bus.daddr_o < 32'(DMEM)) ?
                        {mem[da + 7'd3], mem[da + 7'd2], mem[da + 7'd1], mem[da]} : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_we) mem[bd_addr] <= bd_data;
    if (bus.we_o != 4'b0000) wr_count <= wr_count + 1;
    for (int i = 0; i < 4; i++)
      if (bus.we_o[i] && bus.daddr_o < 32'(DMEM)) mem[da + 7'(i)] <= bus.dwdata_o[8*i +: 8];
  end

  task automatic set_byte(input int a, input logic [7:0] v);
    bd_we = 1'b1; bd_addr = 7'(a); bd_data = v; ref_mem[a] = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic set_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) set_byte(a + i, w[8*i +: 8]);
  endtask

  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e);
    int b, o;
    logic ill, oob, mis, span;
    logic [31:0] v;
    b    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o    = int'(addr[1:0]);
    ill  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
           (st && (f3 == 3'b100 || f3 == 3'b101));
    oob  = (64'(addr) + 64'(b) - 64'd1) >= 64'(DMEM);
`ifdef LSU_MISALIGNED_EN
    mis  = 1'b0;
`else
    mis  = (o % b) != 0;
`endif
    span    = (o + b) > 4;
    e.err   = ill || oob || mis;
    e.rdata = '0;
    e.lat   = e.err ? 1 : (span ? 3 : 2);
    if (!e.err) begin
      if (st) begin
        for (int i = 0; i < b; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < b; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
        case (f3)
          3'b000:  v = {{24{v[7]}}, v[7:0]};
          3'b001:  v = {{16{v[15]}}, v[15:0]};
          default: ;
        endcase
        e.rdata = v;
      end
    end
  endtask

  // drives a request, returns at the start of the cycle after the accepting edge
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    exp_t e;
    int n;
    model(st, f3, addr, wd, e);
    exp_q.push_back(e);
    bus.req_i = 1'b1; bus.st_i = st; bus.funct3_i = f3; bus.addr_i = addr; bus.wdata_i = wd;
    n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 20) begin @(negedge clk); n++; end
    if (!bus.ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: ready_o=%b after %0d cycles, want 1", bus.ready_o, n);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    bus.req_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d completions pending, want 0", exp_q.size());
      exp_q.delete(); acc_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    exp_t e;
    int a;
    forever begin
      @(negedge clk);
      if (reset && bus.req_i && bus.ready_o) begin acc_q.push_back(cyc); acc_log.push_back(cyc); end
      if (bus.done_o) begin
        done_log.push_back(cyc);
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected_done: done_o=1 at cycle %0d, want no completion", cyc);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          n_cmp++;
          if (bus.err_o !== e.err) begin
            n_bad++; $display("FAIL sb_err: got %b want %b (cycle %0d)", bus.err_o, e.err, cyc);
          end
          n_cmp++;
          if (bus.rdata_o !== e.rdata) begin
            n_bad++; $display("FAIL sb_rdata: got %h want %h (cycle %0d)", bus.rdata_o, e.rdata, cyc);
          end
          n_cmp++;
          if (cyc - a !== e.lat) begin
            n_bad++; $display("FAIL sb_latency: got %0d want %0d (cycle %0d)", cyc - a, e.lat, cyc);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.req_i = 1'b0; bus.st_i = 1'b0; bus.funct3_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    reset = 1'b0;
    for (int i = 0; i < DMEM; i++) set_byte(i, 8'(i * 37 + 5));
    @(negedge clk);
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    n_cmp++; if (bus.rdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_o); end
    n_cmp++; if (bus.we_o !== 4'h0) begin n_bad++; $display("FAIL reset_we: got %b want 0000", bus.we_o); end
    n_cmp++; if (bus.daddr_o !== 32'h0) begin n_bad++; $display("FAIL reset_daddr: got %h want 0", bus.daddr_o); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: ready=%b done=%b want 1/0", bus.ready_o, bus.done_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    set_word(32'h10, 32'h8899AABB);
    issue(1'b0, 3'b010, 32'h10, '0);
    wait_drain();
    set_byte(32'h13, 8'h80);
    issue(1'b0, 3'b000, 32'h13, '0);
    issue(1'b0, 3'b100, 32'h13, '0);
    issue(1'b0, 3'b001, 32'h12, '0);
    issue(1'b0, 3'b101, 32'h12, '0);
    issue(1'b0, 3'b000, 32'h11, '0);
    issue(1'b0, 3'b001, 32'h10, '0);
    wait_drain();
  endtask

  task automatic test_store();
    issue(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    issue(1'b1, 3'b000, 32'h45, 32'h000000A5);
    issue(1'b1, 3'b001, 32'h4A, 32'h0000BEEF);
    issue(1'b1, 3'b000, 32'h4F, 32'hFFFFFF7E);
    for (int a = 32'h40; a < 32'h50; a += 4) issue(1'b0, 3'b010, 32'(a), '0);
    issue(1'b0, 3'b000, 32'h4F, '0);
    wait_drain();
  endtask

  task automatic test_misaligned();
    issue(1'b1, 3'b010, 32'h21, 32'h11223344);
`ifdef LSU_MISALIGNED_EN
    @(negedge clk);
    n_cmp++; if (bus.daddr_o !== 32'h20) begin n_bad++; $display("FAIL span_acc1_addr: got %h want 00000020", bus.daddr_o); end
    n_cmp++; if (bus.we_o !== 4'b1110) begin n_bad++; $display("FAIL span_acc1_we: got %b want 1110", bus.we_o); end
    n_cmp++; if (bus.dwdata_o !== 32'h22334400) begin n_bad++; $display("FAIL span_acc1_data: got %h want 22334400", bus.dwdata_o); end
    @(negedge clk);
    n_cmp++; if (bus.daddr_o !== 32'h24) begin n_bad++; $display("FAIL span_acc2_addr: got %h want 00000024", bus.daddr_o); end
    n_cmp++; if (bus.we_o !== 4'b0001) begin n_bad++; $display("FAIL span_acc2_we: got %b want 0001", bus.we_o); end
    n_cmp++; if (bus.dwdata_o !== 32'h00000011) begin n_bad++; $display("FAIL span_acc2_data: got %h want 00000011", bus.dwdata_o); end
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.we_o !== 4'b0000) begin n_bad++; $display("FAIL misal_no_write: got %b want 0000", bus.we_o); end
    end
`endif
    wait_drain();
    issue(1'b0, 3'b010, 32'h20, '0);
    issue(1'b0, 3'b010, 32'h24, '0);
    issue(1'b0, 3'b001, 32'h13, '0);
    issue(1'b0, 3'b101, 32'h27, '0);
    issue(1'b0, 3'b010, 32'h22, '0);
    issue(1'b1, 3'b001, 32'h2B, 32'h00005A6B);
    issue(1'b0, 3'b010, 32'h28, '0);
    issue(1'b0, 3'b010, 32'h2C, '0);
    wait_drain();
  endtask

  task automatic test_errors();
    int w0;
    w0 = wr_count;
    issue(1'b0, 3'b001, 32'h7F, '0);
    issue(1'b0, 3'b011, 32'h10, '0);
    issue(1'b1, 3'b100, 32'h10, 32'hFF);
    issue(1'b1, 3'b101, 32'h10, 32'hFFFF);
    issue(1'b1, 3'b111, 32'h10, 32'h1);
    issue(1'b1, 3'b001, 32'h7F, 32'hFFFF);
    issue(1'b1, 3'b010, 32'h80, 32'hFFFFFFFF);
    issue(1'b1, 3'b010, 32'hFFFFFFFC, 32'h12345678);
    issue(1'b0, 3'b010, 32'h7C, '0);
    wait_drain();
    n_cmp++; if (wr_count !== w0) begin n_bad++; $display("FAIL err_no_write: got %0d write cycles want %0d", wr_count, w0); end
    issue(1'b1, 3'b000, 32'h7F, 32'h3C);
    issue(1'b0, 3'b100, 32'h7F, '0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    acc_log.delete(); done_log.delete();
    set_word(32'h50, 32'h01234567);
    set_word(32'h54, 32'h89ABCDEF);
    issue(1'b0, 3'b010, 32'h50, '0);
    issue(1'b0, 3'b010, 32'h54, '0);
    issue(1'b1, 3'b010, 32'h58, 32'h0BADF00D);
    issue(1'b0, 3'b010, 32'h58, '0);
    wait_drain();
    n_cmp++;
    if (acc_log.size() < 4 || done_log.size() < 4) begin
      n_bad++; $display("FAIL b2b_count: got %0d/%0d accepts/dones want 4/4", acc_log.size(), done_log.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (acc_log[i] !== done_log[i-1]) begin
          n_bad++; $display("FAIL b2b_accept_in_done: accept %0d at cycle %0d want %0d", i, acc_log[i], done_log[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
`ifdef LSU_MISALIGNED_EN
    a = 32'h65;
`else
    a = 32'h30;
`endif
    bus.req_i = 1'b1; bus.st_i = 1'b1; bus.funct3_i = 3'b010; bus.addr_i = a; bus.wdata_i = 32'hA1B2C3D4;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    @(negedge clk);
`ifdef LSU_MISALIGNED_EN
    @(negedge clk);
    n_cmp++; if (bus.we_o !== 4'b0001) begin n_bad++; $display("FAIL abort_pre_we: got %b want 0001", bus.we_o); end
    ref_mem[32'h65] = 8'hD4; ref_mem[32'h66] = 8'hC3; ref_mem[32'h67] = 8'hB2;
`else
    n_cmp++; if (bus.we_o !== 4'b1111) begin n_bad++; $display("FAIL abort_pre_we: got %b want 1111", bus.we_o); end
`endif
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.we_o !== 4'b0000) begin n_bad++; $display("FAIL abort_we: got %b want 0000", bus.we_o); end
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", bus.ready_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", bus.done_o); end
    n_cmp++; if (bus.daddr_o !== 32'h0) begin n_bad++; $display("FAIL abort_daddr: got %h want 0", bus.daddr_o); end
    if (acc_q.size() != 0) void'(acc_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.done_o !== 1'b0 || bus.ready_o !== 1'b1) begin
        n_bad++; $display("FAIL abort_idle: done=%b ready=%b want 0/1", bus.done_o, bus.ready_o);
      end
    end
    @(posedge clk); #1;
    issue(1'b0, 3'b010, 32'h64, '0);
    issue(1'b0, 3'b010, 32'h68, '0);
    wait_drain();
  endtask

  task automatic test_mem_image();
    int bad = 0;
    for (int i = 0; i < DMEM; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL mem_image: %0d bytes differ, want 0", bad); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork monitor(); join_none
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_mem_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_align.md
LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 Parameter: DMEM_BYTES, default 128, size of the data memory in bytes; a power of two of at least 8.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_i  input  1  access request from the pipeline; sampled only while ready_o=1.
REQ-005 st_i  input  1  1=store, 0=load.
REQ-006 funct3_i  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr_i  input  32  byte address.
REQ-008 wdata_i  input  32  store data, right-justified.
REQ-009 ready_o  output  1  block can accept a request this cycle.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 err_o  output  1  completion with error; valid only when done_o=1.
REQ-012 rdata_o  output  32  extended load result; valid only when done_o=1.
REQ-013 daddr_o  output  32  word-aligned address to the data memory.
REQ-014 dwdata_o  output  32  lane-aligned write data to the data memory.
REQ-015 we_o  output  4  per-byte write enables to the data memory.
REQ-016 drdata_i  input  32  combinational read data from the data memory.

Function
REQ-017 States SHALL be IDLE, ACC1, ACC2 and DONE; ready_o=1 in IDLE and in DONE.
REQ-018 A request accepted at edge N SHALL capture addr_i, st_i, funct3_i and wdata_i, then enter ACC1 at N+1 (or DONE directly if illegal).
REQ-019 Byte count SHALL be b: B/BU=1, H/HU=2, W=4; offset o=addr[1:0]; mask m = ((1<<b)-1) << o, 8 bits wide.
REQ-020 In ACC1: daddr_o = addr & ~3, we_o = m[3:0] if store else 0, dwdata_o = wdata << 8*o.
REQ-021 In ACC2: daddr_o = (addr & ~3) + 4 modulo 2^32, we_o = m[7:4] if store else 0, dwdata_o = wdata >> 8*(4-o).
REQ-022 An access SHALL be spanning when o+b > 4; a spanning access goes ACC1 -> ACC2 -> DONE, a non-spanning access goes ACC1 -> DONE.
REQ-023 drdata_i SHALL be captured at the end of ACC1 into lo and at the end of ACC2 into hi; result = ({hi,lo} >> 8*o), truncated to b bytes.
REQ-024 B/H results SHALL be sign-extended; BU/HU results zero-extended; W passed as-is; store completion drives rdata_o=0.
REQ-025 Latency from acceptance to done_o SHALL be 2 cycles for a non-spanning access and 3 cycles for a spanning access.
REQ-026 Illegal funct3 (011, 110, 111, or store with 100/101) SHALL go IDLE -> DONE with err_o=1, we_o never asserted.
REQ-027 An access whose last byte address is >= DMEM_BYTES SHALL complete with err_o=1 and issue no write in any cycle.
REQ-028 In DONE with req_i=1, the new request SHALL be accepted on the same edge that leaves DONE (back-to-back); otherwise the FSM returns to IDLE.
REQ-029 Outside ACC1/ACC2, we_o=0 and daddr_o=dwdata_o=0.

Reset
REQ-030 Reset assertion SHALL immediately force IDLE, ready_o=1, done_o=0, err_o=0, rdata_o=0 and we_o=0, including mid-access.
REQ-031 A write lane already committed in ACC1 is not rolled back; an aborted access produces no done_o.

Configuration
REQ-032 Macro LSU_MISALIGNED_EN: when defined, spanning accesses are split per REQ-022.
REQ-033 When LSU_MISALIGNED_EN is not defined, ACC2 SHALL NOT exist and any access with o mod b != 0 SHALL complete IDLE -> DONE with err_o=1 and no write.

Verification
REQ-034 LW addr=0x10, memory word 0x8899AABB -> done_o at acceptance+2, rdata_o=0x8899AABB, err_o=0.
REQ-035 LB addr=0x13, byte 0x80 -> rdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-036 SW addr=0x21, wdata=0x11223344 (MISALIGNED_EN) -> ACC1 we_o=1110 with dwdata_o=0x22334400 at 0x20, ACC2 we_o=0001 with dwdata_o=0x00000011 at 0x24, done_o at acceptance+3.
REQ-037 Same SW without the macro -> done_o+err_o at acceptance+1, we_o=0 throughout.
REQ-038 LH addr=0x7F with DMEM_BYTES=128 -> err_o=1, no write; funct3=011 -> err_o=1.
REQ-039 Reset driven low during ACC2 of a spanning SW -> we_o=0 immediately, state IDLE, no done_o; back-to-back LW requests complete on consecutive DONE cycles.
